// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   uart_state_e   : serializer/deserializer frame state
//   UART_DATA_BITS : data bits per frame
//   uart_parity()  : even-parity bit of one data byte (XOR reduction)
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  function automatic logic uart_parity(input logic [UART_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO of bytes between the transmit handshake
// and the serializer. Read data is fall-through (head entry always visible).
// Ports:
//   clk, rstn_i      : clock, asynchronous active-low reset
//   push_i, data_i   : write request and byte
//   pop_i, data_o    : read request and head byte
//   full_o, empty_o  : occupancy flags
// A push on a full FIFO is taken when a pop happens in the same cycle.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rstn_i,
  input  logic                      push_i,
  input  logic [UART_DATA_BITS-1:0] data_i,
  input  logic                      pop_i,
  output logic [UART_DATA_BITS-1:0] data_o,
  output logic                      full_o,
  output logic                      empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [UART_DATA_BITS-1:0] mem_q [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter. Frame = start(0), 8 data bits LSB first,
// even parity, stop(1). One bit period = clk_div_i+1 clk cycles, the same
// divider convention as the receiver.
// Ports:
//   clk, rstn_i           : clock, asynchronous active-low reset
//   tx_enable_i           : enable; low aborts the current frame at once
//   clk_div_i[31:0]       : baud divider
//   tx_data_i, tx_valid_i : byte and valid; accepted when valid && ready
//   tx_ready_o            : a byte can be accepted this cycle
//   tx_busy_o             : registered, frame in progress
//   tx_o                  : registered serial line, idle high
// Build option: define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry byte
// FIFO in front of the serializer (back-to-back frames, ready = !full).
// Handshake: a byte transfers on the rising edge where tx_valid_i and
// tx_ready_o are both high; tx_data_i is sampled only on that edge and
// tx_valid_i may change freely while tx_ready_o is low.
module uart_tx
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rstn_i,
  input  logic        tx_enable_i,
  input  logic [31:0] clk_div_i,
  input  logic [7:0]  tx_data_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic        tx_busy_o,
  output logic        tx_o
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("uart_tx: FIFO_DEPTH must be a power of two >= 2");
  end

  uart_state_e               state_q, state_d;
  logic [31:0]               baud_cnt_q, baud_cnt_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]                bit_cnt_q, bit_cnt_d;
  logic                      parity_q, parity_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;

  logic                      baud_tick;
  logic                      byte_avail;  // a byte is available to start a frame
  logic                      load;        // start a frame with load_data
  logic [UART_DATA_BITS-1:0] load_data;

`ifdef UART_TX_FIFO_EN
  logic fifo_full, fifo_empty, fifo_push;

  assign tx_ready_o = !fifo_full;
  assign fifo_push  = tx_valid_i && tx_ready_o;
  assign byte_avail = !fifo_empty;

  uart_tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rstn_i (rstn_i),
    .push_i (fifo_push),
    .data_i (tx_data_i),
    .pop_i  (load),
    .data_o (load_data),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );
`else
  // Ready already implies IDLE, so no byte is ever offered at end of STOP.
  assign tx_ready_o = tx_enable_i && (state_q == ST_IDLE);
  assign byte_avail = tx_valid_i && tx_ready_o;
  assign load_data  = tx_data_i;
`endif

  assign baud_tick = (baud_cnt_q == clk_div_i);

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    parity_d   = parity_q;
    load       = 1'b0;
    if (!tx_enable_i) begin
      state_d    = ST_IDLE;
      baud_cnt_d = '0;
    end else begin
      if (state_q != ST_IDLE) baud_cnt_d = baud_tick ? '0 : baud_cnt_q + 32'd1;
      unique case (state_q)
        ST_IDLE: begin
          baud_cnt_d = '0;
          load       = byte_avail;
        end
        ST_START:  if (baud_tick) state_d = ST_DATA;
        ST_DATA: begin
          if (baud_tick) begin
            shift_d   = shift_q >> 1;
            parity_d  = parity_q ^ shift_q[0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'(UART_DATA_BITS - 1)) state_d = ST_PARITY;
          end
        end
        ST_PARITY: if (baud_tick) state_d = ST_STOP;
        ST_STOP: begin
          if (baud_tick) begin
            state_d = ST_IDLE;
            load    = byte_avail;  // chain the next frame with no idle gap
          end
        end
        default:   state_d = ST_IDLE;
      endcase
      if (load) begin
        state_d    = ST_START;
        shift_d    = load_data;
        bit_cnt_d  = '0;
        parity_d   = 1'b0;
        baud_cnt_d = '0;
      end
    end
    // Line level is derived from the next state so tx_o lines up with state_q.
    tx_d = 1'b1;
    unique case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = parity_d;
      default:   tx_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_o      = tx_q;
  assign tx_busy_o = busy_q;

endmodule
